mdu_seq: RTL
============

Name: mdu_seq

Overview:
- Iterative multiply/divide sequencer for the execute stage.
- Accepts one M-extension op per handshake, using the one-hot op encoding the decoder emits on alu_op[16:12] plus its 32-bit-word flag.
- Runs a radix-2 shift-add multiply or a restoring divide over multiple cycles, then holds the result until the consumer takes it.
- The pipeline stalls on in_ready/out_valid.

Parameters:
- WIDTH, 64, datapath width; full-width ops iterate WIDTH times, word ops iterate 32 times.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- flush  input  1  synchronous abort of any op in flight.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request this cycle.
- op  input  5  one-hot {remu, remw, divu, div, mul}, same order as alu_op[16:12].
- word  input  1  32-bit variant (mulw/divw/remw); only low 32 bits of the sources are used.
- src1  input  WIDTH  multiplicand / dividend.
- src2  input  WIDTH  multiplier / divisor.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  final result.
- busy  output  1  high in BUSY or DONE.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; out_valid=0; result=0; busy=0; iteration counter=0.
  - in_ready=1 immediately after rst is deasserted.
- States:
  - IDLE: in_ready=!flush. On in_valid&in_ready, latch op/word/operands. Go to BUSY, or to DONE for special cases.
  - BUSY: one iteration per cycle, counter decrements from N (N=32 if word, else WIDTH). When the last iteration completes, go to DONE.
  - DONE: out_valid=1, result stable.
    - On out_ready=1 with in_valid=0, go to IDLE.
    - On out_ready=1 with in_valid=1, accept the new request in the same cycle (in_ready=out_ready in DONE). This gives back-to-back operation with no bubble.
- Latency:
  - Normal op: out_valid rises N+1 cycles after the accepting edge.
  - Special case: out_valid rises 1 cycle after the accepting edge.
- Operand preparation:
  - Word ops use src[31:0].
  - Signed ops (div, divw, remw) take absolute values at the operand width (32 or WIDTH).
  - Unsigned ops (divu, remu, mul) use operands as-is.
- Multiply (mul, mulw):
  - Unsigned shift-add; only the low N bits of the product are kept. These low bits are identical for signed and unsigned operands.
- Divide:
  - Restoring algorithm producing quotient and remainder at width N.
  - Signed fixup: quotient negated if operand signs differ; remainder takes the dividend's sign.
  - div/divu return the quotient; remu/remw return the remainder; divw returns the 32-bit quotient.
- Word results: result = sign-extension of the 32-bit value from bit 31 to WIDTH.
- Special cases (detected at accept; go directly to DONE):
  - Divisor==0: quotient = all ones at width N, sign-extended; remainder = dividend at width N, sign-extended for word ops.
  - Signed overflow (dividend = most-negative N-bit value, divisor = -1): quotient = dividend; remainder = 0.
  - op not exactly one-hot: result = 0.
- flush:
  - Highest priority in every state. The next edge forces IDLE, out_valid=0, busy=0, counter=0.
  - In the flush cycle in_ready=0, and no request is accepted.
  - A result held in DONE is discarded, even if out_ready=1 in that cycle.
- Handshake stability:
  - in_valid is not required to stay high without acceptance; requests are sampled only on in_valid&in_ready.
  - result and out_valid must not change in DONE until out_ready or flush.
- Asserting rst mid-operation behaves exactly like reset from idle. No partial result is ever presented.

Test Plan:
- Reset then idle: rst=0 for 3 cycles, release -> in_ready=1, out_valid=0, result=0, busy=0.
- Multiply: mul src1=0xFFFF_FFFF_FFFF_FFFD (-3), src2=7 -> out_valid 65 cycles after accept, result=0xFFFF_FFFF_FFFF_FFEB.
  - mulw src1=0x8000_0000, src2=2 -> 33 cycles, result=0.
- Divide/remainder:
  - div -7/2 -> 0xFFFF_FFFF_FFFF_FFFD.
  - remw src1=0xFFFF_FFF9 (-7), src2=2 -> 0xFFFF_FFFF_FFFF_FFFF.
  - divu 100/7 -> 14.
  - remu 100/7 -> 2.
- Special cases, 1-cycle latency:
  - divu x/0 -> all ones.
  - remu 0x1234/0 -> 0x1234.
  - div 0x8000_0000_0000_0000/-1 -> 0x8000_0000_0000_0000.
  - divw src1=0x8000_0000, src2=0xFFFF_FFFF -> 0xFFFF_FFFF_8000_0000.
- Handshake/back-to-back:
  - Hold out_ready=0 for 5 cycles in DONE -> result stable and out_valid=1 throughout.
  - Then out_ready=1 with in_valid=1 (divu 9/3) -> accepted the same cycle; next result=3 with no idle cycle.
- Abort:
  - flush at BUSY iteration 10 of a div -> IDLE next cycle, out_valid never asserts.
  - rst=0 mid-BUSY -> outputs at reset values immediately.
  - The next op after either abort completes correctly.

Source files
------------

// File: rtl/mdu_seq.sv
// Iterative multiply/divide sequencer: radix-2 shift-add multiply and restoring
// divide, one iteration per cycle, result held until the consumer takes it.
module mdu_seq #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic             word,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MASK32 = {{(WIDTH-32){1'b0}}, 32'hFFFF_FFFF};

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d, a_q, a_d, b_q, b_d, result_q, result_d;
  logic             word_q, word_d, mul_q, mul_d, quot_q, quot_d;
  logic             qneg_q, qneg_d, rneg_q, rneg_d;

  function automatic logic [WIDTH-1:0] sext_n(input logic [WIDTH-1:0] v, input logic w);
    return w ? {{(WIDTH-32){v[31]}}, v[31:0]} : v;
  endfunction

  // Operand preparation and special-case detection for the incoming request
  logic             is_signed, is_div, quot_op, onehot, neg1, neg2, div0, ovf, special;
  logic [WIDTH-1:0] mask_n, min_n, x1, x2, mag1, mag2, spec_res;

  always_comb begin
    is_signed = op[1] | op[3];
    is_div    = |op[4:1];
    quot_op   = op[1] | op[2];
    onehot    = (op != 5'd0) && ((op & (op - 5'd1)) == 5'd0);
    mask_n    = word ? MASK32 : '1;
    min_n     = word ? {{(WIDTH-32){1'b0}}, 1'b1, 31'd0} : {1'b1, {(WIDTH-1){1'b0}}};
    x1        = src1 & mask_n;
    x2        = src2 & mask_n;
    neg1      = is_signed & (word ? src1[31] : src1[WIDTH-1]);
    neg2      = is_signed & (word ? src2[31] : src2[WIDTH-1]);
    mag1      = neg1 ? ((-x1) & mask_n) : x1;
    mag2      = neg2 ? ((-x2) & mask_n) : x2;
    div0      = is_div && (x2 == '0);
    ovf       = is_signed && (x1 == min_n) && (x2 == mask_n);
    special   = !onehot || div0 || ovf;
    spec_res  = '0;
    if (onehot && div0)
      spec_res = quot_op ? '1 : sext_n(x1, word);
    else if (onehot && ovf)
      spec_res = quot_op ? sext_n(x1, word) : '0;
  end

  // One iteration of each algorithm, computed from the current registers
  logic [WIDTH:0]   sh, diff;
  logic             ge;
  logic [WIDTH-1:0] rem_n, quo_n, q_fin, quot_fin, rem_fin, prod_n;

  always_comb begin
    sh       = {acc_q, a_q[WIDTH-1]};
    diff     = sh - {1'b0, b_q};
    ge       = sh >= {1'b0, b_q};
    rem_n    = ge ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
    quo_n    = {a_q[WIDTH-2:0], ge};
    q_fin    = word_q ? (quo_n & MASK32) : quo_n;
    quot_fin = qneg_q ? -q_fin : q_fin;
    rem_fin  = rneg_q ? -rem_n : rem_n;
    prod_n   = b_q[0] ? acc_q + a_q : acc_q;
  end

  assign in_ready  = !flush && ((state_q == S_IDLE) || ((state_q == S_DONE) && out_ready));
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign result    = result_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    word_d   = word_q;
    mul_d    = mul_q;
    quot_d   = quot_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_BUSY: begin
          if (mul_q) begin
            acc_d = prod_n;
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
          end else begin
            acc_d = rem_n;
            a_d   = quo_n;
          end
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d  = S_DONE;
            result_d = sext_n(mul_q ? prod_n : (quot_q ? quot_fin : rem_fin), word_q);
          end
        end
        S_DONE: if (out_ready) state_d = S_IDLE;
        default: ;
      endcase
      // A new request in DONE overrides the return to IDLE, giving back-to-back ops
      if (in_valid && in_ready) begin
        word_d = word;
        mul_d  = op[0];
        quot_d = quot_op;
        qneg_d = neg1 ^ neg2;
        rneg_d = neg1;
        acc_d  = '0;
        a_d    = (word && !op[0]) ? (mag1 << (WIDTH - 32)) : mag1;
        b_d    = mag2;
        if (special) begin
          state_d  = S_DONE;
          cnt_d    = '0;
          result_d = spec_res;
        end else begin
          state_d = S_BUSY;
          cnt_d   = word ? CW'(32) : CW'(WIDTH);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      word_q   <= 1'b0;
      mul_q    <= 1'b0;
      quot_q   <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      word_q   <= word_d;
      mul_q    <= mul_d;
      quot_q   <= quot_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
    end
  end

endmodule
